// File: rtl/frame_painter.sv
// Raster sweep stage: walks every pixel, registers the renderer's colour and drives the VGA write port.
// Optional dropped-tick counter enabled by defining PAINTER_OVERRUN_CNT_EN.
module frame_painter #(
    parameter int H_PIXELS = 160,
    parameter int V_PIXELS = 120
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       frame_tick,
    input  logic [7:0] yasu_x_in,
    input  logic [6:0] yasu_y_in,
    output logic [7:0] pix_x,
    output logic [6:0] pix_y,
    output logic [7:0] yasu_x,
    output logic [6:0] yasu_y,
    input  logic [2:0] colour_in,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       frame_done
`ifdef PAINTER_OVERRUN_CNT_EN
    ,
    output logic [7:0] overrun_cnt
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [7:0] X_LAST = 8'(H_PIXELS - 1);
    localparam logic [6:0] Y_LAST = 7'(V_PIXELS - 1);

    logic [1:0] state_q, state_d;
    logic       pending_q, pending_d;
    logic [7:0] pix_x_q, pix_x_d;
    logic [6:0] pix_y_q, pix_y_d;
    logic [7:0] yasu_x_q, yasu_x_d;
    logic [6:0] yasu_y_q, yasu_y_d;
    logic [7:0] vga_x_q, vga_x_d;
    logic [6:0] vga_y_q, vga_y_d;
    logic [2:0] vga_colour_q, vga_colour_d;
    logic       vga_plot_q, vga_plot_d;
    logic       busy_q, busy_d;
    logic       frame_done_q, frame_done_d;
`ifdef PAINTER_OVERRUN_CNT_EN
    logic [7:0] overrun_q, overrun_d;
`endif

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        yasu_x_d     = yasu_x_q;
        yasu_y_d     = yasu_y_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
`ifdef PAINTER_OVERRUN_CNT_EN
        overrun_d    = overrun_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (frame_tick || pending_q) begin
                    state_d   = S_SCAN;
                    yasu_x_d  = yasu_x_in;
                    yasu_y_d  = yasu_y_in;
                    pix_x_d   = 8'd0;
                    pix_y_d   = 7'd0;
                    pending_d = 1'b0;
                end
            end
            S_SCAN: begin
                vga_x_d      = pix_x_q;
                vga_y_d      = pix_y_q;
                vga_colour_d = colour_in;
                if (pix_x_q == X_LAST) begin
                    pix_x_d = 8'd0;
                    if (pix_y_q == Y_LAST) begin
                        pix_y_d = 7'd0;
                        state_d = S_DONE;
                    end else begin
                        pix_y_d = pix_y_q + 7'd1;
                    end
                end else begin
                    pix_x_d = pix_x_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Only one redraw request can be queued while a frame is in flight.
        if (frame_tick && (state_q != S_IDLE)) begin
            if (!pending_q) begin
                pending_d = 1'b1;
            end
`ifdef PAINTER_OVERRUN_CNT_EN
            else if (overrun_q != 8'hFF) begin
                overrun_d = overrun_q + 8'd1;
            end
`endif
        end

        vga_plot_d   = (state_q == S_SCAN);
        frame_done_d = (state_q == S_DONE);
        busy_d       = (state_d == S_SCAN);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            pending_q    <= 1'b0;
            pix_x_q      <= 8'd0;
            pix_y_q      <= 7'd0;
            yasu_x_q     <= 8'd0;
            yasu_y_q     <= 7'd0;
            vga_x_q      <= 8'd0;
            vga_y_q      <= 7'd0;
            vga_colour_q <= 3'd0;
            vga_plot_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef PAINTER_OVERRUN_CNT_EN
            overrun_q    <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            yasu_x_q     <= yasu_x_d;
            yasu_y_q     <= yasu_y_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
`ifdef PAINTER_OVERRUN_CNT_EN
            overrun_q    <= overrun_d;
`endif
        end
    end

    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign yasu_x     = yasu_x_q;
    assign yasu_y     = yasu_y_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
`ifdef PAINTER_OVERRUN_CNT_EN
    assign overrun_cnt = overrun_q;
`endif

endmodule

// File: tb/tb_frame_painter.sv
// Directed bench for frame_painter: full-frame sweeps, colour path, sprite snapshot,
// queued/dropped ticks and asynchronous reset mid-frame.
module tb_frame_painter;

    localparam int H = 160;
    localparam int V = 120;

    logic       clk = 1'b0;
    logic       resetn;
    logic       frame_tick;
    logic [7:0] yasu_x_in;
    logic [6:0] yasu_y_in;
    logic [7:0] pix_x;
    logic [6:0] pix_y;
    logic [7:0] yasu_x;
    logic [6:0] yasu_y;
    logic [2:0] colour_in;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic       frame_done;
`ifdef PAINTER_OVERRUN_CNT_EN
    logic [7:0] overrun_cnt;
`endif

    int checks = 0;
    int errors = 0;

    frame_painter #(.H_PIXELS(H), .V_PIXELS(V)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .frame_tick (frame_tick),
        .yasu_x_in  (yasu_x_in),
        .yasu_y_in  (yasu_y_in),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .yasu_x     (yasu_x),
        .yasu_y     (yasu_y),
        .colour_in  (colour_in),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy),
        .frame_done (frame_done)
`ifdef PAINTER_OVERRUN_CNT_EN
        ,
        .overrun_cnt(overrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in renderer: one marked pixel, everything else white.
    always_comb colour_in = (pix_x == 8'd10 && pix_y == 7'd5) ? 3'b011 : 3'b111;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        logic [63:0] v;
        v = {13'd0, pix_x, pix_y, yasu_x, yasu_y, vga_x, vga_y, vga_colour, vga_plot, busy, frame_done};
        check(tag, v, 64'd0);
        check({tag, "_plot"}, {63'd0, vga_plot}, 64'd0);
`ifdef PAINTER_OVERRUN_CNT_EN
        check({tag, "_ovr"}, {56'd0, overrun_cnt}, 64'd0);
`endif
    endtask

    // Observe n_pix consecutive plot cycles starting at pixel (0,0).
    task automatic scan_frame(input string tag, input int n_pix, input logic [7:0] exp_yx,
                              input logic [6:0] exp_yy, input bit inject);
        int bad_xy = 0, bad_plot = 0, bad_busy = 0, bad_col = 0, bad_yasu = 0, hits = 0;
        int ex, ey;
        logic [2:0] exp_col;
        for (int i = 0; i < n_pix; i++) begin
            @(negedge clk);
            if (inject) begin
                frame_tick = (i == 1000 || i == 2000 || i == 3000);
                if (i == 5000) begin
                    yasu_x_in = 8'd90;
                    yasu_y_in = 7'd20;
                end
            end
            ex = i % H;
            ey = i / H;
            exp_col = (ex == 10 && ey == 5) ? 3'b011 : 3'b111;
            if (vga_plot !== 1'b1) bad_plot++;
            if (vga_x !== ex[7:0] || vga_y !== ey[6:0]) bad_xy++;
            if (vga_colour !== exp_col) bad_col++;
            if (yasu_x !== exp_yx || yasu_y !== exp_yy) bad_yasu++;
            if (busy !== (i != H * V - 1)) bad_busy++;
            if (vga_colour === 3'b011) hits++;
        end
        frame_tick = 1'b0;
        check({tag, "_plot_gaps"}, bad_plot, 0);
        check({tag, "_pixel_order"}, bad_xy, 0);
        check({tag, "_colour"}, bad_col, 0);
        check({tag, "_yasu_stable"}, bad_yasu, 0);
        check({tag, "_busy"}, bad_busy, 0);
        check({tag, "_marked_hits"}, hits, (n_pix > 5 * H + 10) ? 1 : 0);
    endtask

    initial begin
        int bad;
        resetn     = 1'b0;
        frame_tick = 1'b0;
        yasu_x_in  = 8'd40;
        yasu_y_in  = 7'd60;
        repeat (3) @(negedge clk);
        check_all_zero("reset_init");
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_tick_busy", busy, 0);

        // Frame A: snapshot (40,60), three ticks mid-scan, sprite moves at pixel 5000.
        pulse_tick();
        check("A_start_busy", busy, 1);
        check("A_start_pix", {pix_x, pix_y}, 15'd0);
        check("A_start_plot", vga_plot, 0);
        check("A_start_yasu", {yasu_x, yasu_y}, {8'd40, 7'd60});
        scan_frame("A", H * V, 8'd40, 7'd60, 1'b1);
        @(negedge clk);
        check("A_end_plot", vga_plot, 0);
        check("A_end_done", frame_done, 1);
        check("A_end_busy", busy, 0);
        check("A_hold_vga", {vga_x, vga_y, vga_colour}, {8'd159, 7'd119, 3'b111});
        check("A_end_pix", {pix_x, pix_y}, 15'd0);
`ifdef PAINTER_OVERRUN_CNT_EN
        check("A_overrun", overrun_cnt, 8'd2);
`endif

        // Queued request restarts immediately with the new sprite position.
        @(negedge clk);
        check("B_done_single", frame_done, 0);
        check("B_restart_busy", busy, 1);
        check("B_restart_plot", vga_plot, 0);
        check("B_yasu", {yasu_x, yasu_y}, {8'd90, 7'd20});
        scan_frame("B", H * V, 8'd90, 7'd20, 1'b0);
        @(negedge clk);
        check("B_end_done", frame_done, 1);
        @(negedge clk);
        check("B_done_single", frame_done, 0);
        repeat (5) @(negedge clk);
        check("B_no_extra_frame", {busy, vga_plot}, 2'b00);

        // Frame C interrupted by an asynchronous reset at pixel 100.
        yasu_x_in = 8'd7;
        yasu_y_in = 7'd9;
        pulse_tick();
        check("C_start_busy", busy, 1);
        scan_frame("C", 100, 8'd7, 7'd9, 1'b0);
        #2 resetn = 1'b0;
        #1 check_all_zero("reset_mid_scan");
        @(negedge clk) resetn = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (frame_done !== 1'b0 || busy !== 1'b0 || vga_plot !== 1'b0) bad++;
        end
        check("post_reset_idle", bad, 0);

        pulse_tick();
        check("D_start_pix", {pix_x, pix_y}, 15'd0);
        check("D_start_yasu", {yasu_x, yasu_y}, {8'd7, 7'd9});
        scan_frame("D", 2 * H, 8'd7, 7'd9, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
